// File: rtl/tpu_job_arbiter.sv
// tpu_job_arbiter
// Shares one 2x2 systolic core between two byte-streaming requesters.
// A job is granted round-robin, its operand bytes are forwarded to the
// core, the core's result bytes are returned tagged with the requester id,
// and the core is reset for one cycle before the next job is arbitrated.
// A job whose core never raises done is aborted with a one-cycle err pulse.

module tpu_job_arbiter #(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_transpose,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_transpose,
  output logic       req1_ready,
  output logic       core_rst,
  output logic       core_load_en,
  output logic [7:0] core_data,
  output logic       core_transpose,
  input  logic       core_done,
  input  logic [7:0] core_outdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_last,
  output logic       busy,
  output logic       err
);

  localparam int IN_W   = $clog2(IN_BYTES + 1);
  localparam int OUT_W  = $clog2(OUT_BYTES + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    DRAIN,
    FLUSH
  } state_t;

  state_t            state;
  logic              gnt;
  logic              last_gnt;
  logic [IN_W-1:0]   in_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic       pick;
  logic       gnt_valid;
  logic [7:0] gnt_data;

  // Arbitration choice for IDLE: a lone requester wins, a tie goes to the
  // requester that was not served last; last_gnt resets to 1 so 0 wins first.
  assign pick = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;

  assign gnt_valid = gnt ? req1_valid : req0_valid;
  assign gnt_data  = gnt ? req1_data  : req0_data;

  assign req0_ready   = (state == LOAD) && (gnt == 1'b0);
  assign req1_ready   = (state == LOAD) && (gnt == 1'b1);
  assign core_load_en = (state == LOAD) && gnt_valid;
  assign core_data    = (state == LOAD) ? gnt_data : 8'h00;
  assign core_rst     = rst || (state == FLUSH);
  assign busy         = (state != IDLE);

  // Job sequencer: grant, stream operands, wait for the core, drain results,
  // then flush the core; all response/status outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gnt            <= 1'b0;
      last_gnt       <= 1'b1;
      in_cnt         <= '0;
      out_cnt        <= '0;
      wait_cnt       <= '0;
      core_transpose <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 8'h00;
      rsp_id         <= 1'b0;
      rsp_last       <= 1'b0;
      err            <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt            <= pick;
            core_transpose <= pick ? req1_transpose : req0_transpose;
            in_cnt         <= '0;
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (gnt_valid) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == IN_W'(IN_BYTES - 1)) begin
              wait_cnt <= '0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (core_done) begin
            rsp_data  <= core_outdata;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt;
            rsp_last  <= (OUT_BYTES == 1);
            out_cnt   <= OUT_W'(1);
            state     <= DRAIN;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= FLUSH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_cnt < OUT_W'(OUT_BYTES)) begin
            rsp_data <= core_outdata;
            out_cnt  <= out_cnt + 1'b1;
            rsp_last <= (out_cnt == OUT_W'(OUT_BYTES - 1));
          end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            last_gnt  <= gnt;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          // Also covers the timeout path, where DRAIN never ran.
          core_transpose <= 1'b0;
          last_gnt       <= gnt;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_job_arbiter.sv
// tb_tpu_job_arbiter
// Randomised bench: two requester drivers, a behavioural 2x2 core model, a
// round-robin reference that queues the expected responses in service
// order, and a monitor that pops and compares whatever the arbiter emits.

module tb_tpu_job_arbiter;

  localparam int IN_BYTES  = 8;
  localparam int OUT_BYTES = 8;
  localparam int TIMEOUT   = 15;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_transpose, req1_transpose;
  logic       req0_ready, req1_ready;
  logic       core_rst, core_load_en, core_transpose;
  logic [7:0] core_data;
  logic       core_done;
  logic [7:0] core_outdata;
  logic       rsp_valid, rsp_id, rsp_last, busy, err;
  logic [7:0] rsp_data;

  tpu_job_arbiter #(
    .IN_BYTES (IN_BYTES),
    .OUT_BYTES(OUT_BYTES),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_transpose(req0_transpose),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_transpose(req1_transpose),
    .req1_ready    (req1_ready),
    .core_rst      (core_rst),
    .core_load_en  (core_load_en),
    .core_data     (core_data),
    .core_transpose(core_transpose),
    .core_done     (core_done),
    .core_outdata  (core_outdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .rsp_last      (rsp_last),
    .busy          (busy),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       is_err;
    logic       id;
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct packed {
    logic       respond;
    logic [3:0] latency;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;

  // Job descriptors written by the main sequence, consumed by the driver.
  logic [63:0] job_ops[2];
  logic        job_tr[2];
  int          job_mode[2];
  logic        job_resp[2];
  int          job_gen[2];
  logic        ref_last;

  // Driver-owned requester state.
  logic active[2];
  int   sent[2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic failNote(input string name, input int actual, input int required);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
  endtask

  // Behaviour of the shared core: 4 weights then 4 inputs (row-major),
  // C = W*X (or W^T*X when transposed), 16-bit c00,c01,c10,c11 high byte first.
  function automatic logic [63:0] coreResult(input logic [63:0] ops, input logic tr);
    int w[2][2];
    int x[2][2];
    int a[2][2];
    logic [15:0] c;
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        w[i][j] = int'(ops[8*(2*i+j) +: 8]);
        x[i][j] = int'(ops[8*(4+2*i+j) +: 8]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        a[i][j] = tr ? w[j][i] : w[i][j];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = 16'(a[i][0] * x[0][j] + a[i][1] * x[1][j]);
        r[8*(2*(2*i+j))   +: 8] = c[15:8];
        r[8*(2*(2*i+j)+1) +: 8] = c[7:0];
      end
    return r;
  endfunction

  task automatic setJob(input int r, input logic [63:0] ops, input logic tr, input int mode, input logic respond);
    job_ops[r]  = ops;
    job_tr[r]   = tr;
    job_mode[r] = mode;
    job_resp[r] = respond;
  endtask

  // Predicts service order with round-robin, queues expected results/errors
  // and core plans, then releases the selected requesters together.
  task automatic applyStimulus(input logic use0, input logic use1);
    int    order[$];
    int    first;
    int    r;
    logic [63:0] res;
    exp_t  e;
    plan_t p;
    if (use0 && use1) begin
      first = ref_last ? 0 : 1;
      order.push_back(first);
      order.push_back(1 - first);
    end else if (use0) begin
      order.push_back(0);
    end else begin
      order.push_back(1);
    end
    foreach (order[i]) begin
      r = order[i];
      p.respond = job_resp[r];
      p.latency = 4'($urandom_range(0, 10));
      plan_q.push_back(p);
      if (job_resp[r]) begin
        res = coreResult(job_ops[r], job_tr[r]);
        for (int k = 0; k < OUT_BYTES; k++) begin
          e.is_err = 1'b0;
          e.id     = r[0];
          e.data   = res[8*k +: 8];
          e.last   = (k == OUT_BYTES - 1);
          exp_q.push_back(e);
        end
      end else begin
        e.is_err = 1'b1;
        e.id     = r[0];
        e.data   = 8'h00;
        e.last   = 1'b0;
        exp_q.push_back(e);
      end
      ref_last = r[0];
    end
    @(posedge clk);
    if (use0) job_gen[0]++;
    if (use1) job_gen[1]++;
  endtask

  task automatic waitRoundDone();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!active[0] && !active[1] && exp_q.size() == 0 && plan_q.size() == 0 && !busy)
        break;
      n++;
      if (n > 600) begin
        failNote("round_done_cycles", n, 600);
        exp_q.delete();
        plan_q.delete();
        break;
      end
    end
  endtask

  // Requester drivers: present the job's bytes, honour ready, apply bubbles.
  initial begin
    logic       v[2];
    logic [7:0] d[2];
    logic       t[2];
    logic       rdy[2];
    logic       prev_acc[2];
    int         taken_gen[2];
    req0_valid = 1'b0; req0_data = 8'h00; req0_transpose = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_transpose = 1'b0;
    for (int r = 0; r < 2; r++) begin
      active[r] = 1'b0;
      sent[r] = 0;
      prev_acc[r] = 1'b0;
      taken_gen[r] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (job_gen[r] != taken_gen[r]) begin
          taken_gen[r] = job_gen[r];
          active[r]    = 1'b1;
          sent[r]      = 0;
          prev_acc[r]  = 1'b0;
        end
        if (active[r]) begin
          case (job_mode[r])
            1:       v[r] = 1'b1;
            2:       v[r] = !prev_acc[r];
            default: v[r] = (sent[r] == 0) || ($urandom_range(0, 3) != 0);
          endcase
          d[r] = job_ops[r][8*sent[r] +: 8];
          t[r] = (sent[r] == 0) ? job_tr[r] : !job_tr[r];
        end else begin
          v[r] = 1'b0;
          d[r] = 8'($urandom);
          t[r] = 1'($urandom);
        end
      end
      req0_valid = v[0]; req0_data = d[0]; req0_transpose = t[0];
      req1_valid = v[1]; req1_data = d[1]; req1_transpose = t[1];
      @(negedge clk);
      rdy[0] = req0_ready;
      rdy[1] = req1_ready;
      if (rdy[0] || rdy[1])
        checkOutput("ready_exclusive", {31'd0, rdy[0] && rdy[1]}, 32'd0);
      for (int r = 0; r < 2; r++) begin
        if (rdy[r])
          checkOutput($sformatf("ready%0d_only_with_job", r), {31'd0, active[r]}, 32'd1);
        prev_acc[r] = v[r] && rdy[r];
        if (prev_acc[r]) begin
          sent[r]++;
          if (sent[r] == IN_BYTES) active[r] = 1'b0;
        end
      end
    end
  end

  // Core model: collects operand strobes, answers after the planned latency
  // (or never, for timeout jobs), and checks the flush that ends each job.
  initial begin
    int          cnt;
    int          countdown;
    int          idx;
    int          wait_negs;
    logic        loaded, streaming, job_active, check_idle;
    logic [63:0] cbuf, res;
    plan_t       cur;
    cnt = 0; countdown = 0; idx = 0; wait_negs = 0;
    loaded = 1'b0; streaming = 1'b0; job_active = 1'b0; check_idle = 1'b0;
    cbuf = '0; res = '0; cur = '0;
    core_done = 1'b0;
    core_outdata = 8'h00;
    forever begin
      @(negedge clk);
      if (check_idle && !rst) begin
        checkOutput("transpose_cleared", {31'd0, core_transpose}, 32'd0);
        checkOutput("idle_after_flush", {31'd0, busy}, 32'd0);
      end
      check_idle = 1'b0;
      if (core_rst) begin
        if (!rst && job_active) begin
          checkOutput("load_strobes", cnt, IN_BYTES);
          if (loaded && !cur.respond) begin
            checkOutput("timeout_wait_cycles", wait_negs, TIMEOUT);
            checkOutput("timeout_err", {31'd0, err}, 32'd1);
          end else begin
            checkOutput("flush_err_low", {31'd0, err}, 32'd0);
          end
          check_idle = 1'b1;
        end
        cnt = 0; countdown = 0; idx = 0; wait_negs = 0;
        loaded = 1'b0; streaming = 1'b0; job_active = 1'b0;
      end else begin
        if (loaded && !streaming) wait_negs++;
        if (core_load_en) begin
          job_active = 1'b1;
          if (cnt < IN_BYTES) cbuf[8*cnt +: 8] = core_data;
          cnt++;
          if (cnt == IN_BYTES) begin
            loaded = 1'b1;
            if (plan_q.size() == 0) begin
              failNote("core_plan_available", 0, 1);
              cur = '0;
            end else begin
              cur = plan_q.pop_front();
            end
            res = coreResult(cbuf, core_transpose);
            countdown = int'(cur.latency);
          end
        end
      end
      @(posedge clk);
      #1;
      if (loaded && cur.respond) begin
        if (!streaming) begin
          if (countdown == 0) begin
            streaming = 1'b1;
            idx = 0;
          end else begin
            countdown--;
          end
        end
        if (streaming) begin
          if (idx < OUT_BYTES) begin
            core_done = (idx == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            core_outdata = res[8*idx +: 8];
            idx++;
          end else begin
            core_done = 1'b0;
            core_outdata = 8'($urandom);
          end
        end else begin
          core_done = 1'b0;
          core_outdata = 8'($urandom);
        end
      end else begin
        core_done = 1'b0;
        core_outdata = 8'($urandom);
      end
    end
  end

  // Monitor: every emitted result byte or err pulse consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          failNote("rsp_expected_queue_size", 0, 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_kind_is_result", {31'd0, e.is_err}, 32'd0);
          if (!e.is_err) begin
            checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
            checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            checkOutput("rsp_last", {31'd0, rsp_last}, {31'd0, e.last});
          end
        end
      end
      if (err) begin
        if (exp_q.size() == 0) begin
          failNote("err_expected_queue_size", 0, 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("err_kind_is_timeout", {31'd0, e.is_err}, 32'd1);
        end
      end
    end
  end

  // Main sequence: reset checks, directed scenarios, random rounds, reset
  // in the middle of a drain, and arbitration restart after that reset.
  initial begin
    int base;
    int n;
    logic u0, u1;
    rst = 1'b1;
    ref_last = 1'b1;
    for (int r = 0; r < 2; r++) begin
      job_gen[r] = 0;
      setJob(r, 64'd0, 1'b0, 1, 1'b1);
    end

    repeat (2) @(negedge clk);
    checkOutput("reset_core_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
    checkOutput("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("reset_rsp_last", {31'd0, rsp_last}, 32'd0);
    checkOutput("reset_core_transpose", {31'd0, core_transpose}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_load_en", {31'd0, core_load_en}, 32'd0);
    checkOutput("reset_core_data", {24'd0, core_data}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_core_rst", {31'd0, core_rst}, 32'd0);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    // Contention straight after reset: 0 then 1, then a second tie goes to 0.
    setJob(0, {$urandom, $urandom}, 1'b0, 1, 1'b1);
    setJob(1, {$urandom, $urandom}, 1'b1, 1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    waitRoundDone();
    setJob(0, {$urandom, $urandom}, 1'b1, 0, 1'b1);
    setJob(1, {$urandom, $urandom}, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    waitRoundDone();

    // Single back-to-back job with bytes 1..8.
    setJob(0, 64'h0807060504030201, 1'b0, 1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    waitRoundDone();

    // Requester 1 alternating valid (bubbles every other cycle).
    setJob(1, {$urandom, $urandom}, 1'b0, 2, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitRoundDone();

    // Core never answers: timeout abort.
    setJob(0, {$urandom, $urandom}, 1'b0, 1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitRoundDone();

    // Transpose requested at grant, flipped for the rest of the load.
    setJob(0, {$urandom, $urandom}, 1'b1, 1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    waitRoundDone();

    // Randomised rounds.
    for (int i = 0; i < 25; i++) begin
      u0 = 1'($urandom_range(0, 1));
      u1 = 1'($urandom_range(0, 1));
      if (!u0 && !u1) u0 = 1'b1;
      for (int r = 0; r < 2; r++)
        setJob(r, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), ($urandom_range(0, 4) != 0));
      applyStimulus(u0, u1);
      waitRoundDone();
    end

    // Reset after three result bytes: job is dropped without a last byte.
    base = rsp_seen;
    setJob(0, {$urandom, $urandom}, 1'b0, 1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_seen >= base + 3) break;
      n++;
      if (n > 200) begin
        failNote("mid_drain_bytes_seen", rsp_seen - base, 3);
        break;
      end
    end
    rst = 1'b1;
    exp_q.delete();
    plan_q.delete();
    @(negedge clk);
    checkOutput("mid_drain_core_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("mid_drain_rsp_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    ref_last = 1'b1;
    @(negedge clk);
    checkOutput("after_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("after_reset_rsp_last", {31'd0, rsp_last}, 32'd0);
    checkOutput("after_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("after_reset_core_rst", {31'd0, core_rst}, 32'd0);

    // Round-robin pointer is back to favouring requester 0.
    setJob(0, {$urandom, $urandom}, 1'b0, 0, 1'b1);
    setJob(1, {$urandom, $urandom}, 1'b1, 0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    waitRoundDone();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_job_arbiter.md
Name: tpu_job_arbiter

Overview:
- Shares the single 2x2 systolic core (control unit, operand memory and array) between two host requesters, one matrix job at a time.
- Round-robin arbitrates between the requesters.
- Streams the granted requester's 8 operand bytes into the core and captures the 8 result bytes the core emits.
- Returns the results tagged with the requester id, then resets the core so the next job starts from IDLE.

Parameters:
- IN_BYTES, 8: operand bytes per job (4 weights, then 4 inputs).
- OUT_BYTES, 8: result bytes per job (c00..c11, high byte first).
- TIMEOUT, 15: maximum WAIT cycles before a job is aborted. Must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operand byte.
- req0_data  in  8  requester 0 operand byte.
- req0_transpose  in  1  requester 0 transpose flag; sampled at grant.
- req0_ready  out  1  requester 0 byte accepted this cycle when valid&ready.
- req1_valid, req1_data, req1_transpose, req1_ready: same as requester 0, for requester 1.
- core_rst  out  1  reset to the core.
- core_load_en  out  1  operand byte strobe to the core.
- core_data  out  8  operand byte to the core memory.
- core_transpose  out  1  transpose control to the core.
- core_done  in  1  core result-ready flag.
- core_outdata  in  8  core result byte stream.
- rsp_valid  out  1  result byte valid.
- rsp_data  out  8  result byte.
- rsp_id  out  1  requester the result belongs to.
- rsp_last  out  1  final result byte of the job.
- busy  out  1  a job is in progress (state != IDLE).
- err  out  1  one-cycle pulse: job aborted by timeout.

Behaviour:
- The only clock is clk. rst is synchronous and active-high.
- Reset values:
  - state IDLE.
  - All registered outputs 0: rsp_valid, rsp_data, rsp_id, rsp_last, core_transpose, err.
  - Counters in_cnt = 0, out_cnt = 0, wait_cnt = 0.
  - Round-robin pointer favours requester 0.
  - core_rst = rst OR (state==FLUSH), combinational. The core is therefore held in reset whenever rst is high.
- Reset mid-job: the job is dropped and no response is produced. The first cycle after rst deasserts is IDLE.
- States: IDLE, LOAD, WAIT, DRAIN, FLUSH.
- IDLE:
  - A requester is "requesting" when its reqN_valid=1.
  - If one requester is requesting, grant it. If both are requesting, grant the one not served last; the tie after reset goes to requester 0.
  - On grant: latch gnt, set core_transpose <= reqN_transpose, in_cnt <= 0, go to LOAD.
  - No byte is accepted in the grant cycle.
- LOAD:
  - req_gnt_ready = 1. The other requester's ready = 0.
  - core_load_en = req_gnt_valid, combinational. core_data = req_gnt_data, combinational; 0 outside LOAD.
  - Each accepted byte increments in_cnt. The IN_BYTES-th accepted byte moves the state to WAIT with wait_cnt <= 0.
  - Bubbles (valid low) stall without counting.
- WAIT:
  - If core_done=1: capture rsp_data <= core_outdata, rsp_valid <= 1, rsp_id <= gnt, out_cnt <= 1, go to DRAIN.
  - Else wait_cnt increments. When wait_cnt==TIMEOUT-1 with core_done=0, pulse err for one cycle and go to FLUSH with no response.
- DRAIN:
  - Each edge while out_cnt < OUT_BYTES: rsp_data <= core_outdata, out_cnt++. rsp_last <= 1 on the edge that captures byte OUT_BYTES-1.
  - When out_cnt==OUT_BYTES: rsp_valid <= 0, rsp_last <= 0, update the round-robin pointer to gnt, go to FLUSH.
  - rsp_valid stays high for exactly OUT_BYTES consecutive cycles. Output has no backpressure.
  - core_done falling during DRAIN is ignored.
- FLUSH:
  - Lasts exactly one cycle with core_rst=1, then returns to IDLE.
  - core_transpose <= 0. On timeout, the round-robin pointer is also updated to gnt.
- busy = (state != IDLE), combinational.
- Simultaneous events:
  - Requests arriving during a job are held off (ready=0) and arbitrated in IDLE after FLUSH.
  - A requester that drops valid mid-LOAD keeps the grant; there is no preemption.

Test Plan:
- Single job: req0 streams bytes 1,2,3,4,5,6,7,8 back-to-back. Required: core_load_en high for exactly 8 cycles with core_data 1..8; then, after core_done, 8 rsp_valid cycles with rsp_id=0, bytes equal to core_outdata, rsp_last on the 8th; then core_rst high for 1 cycle; busy returns to 0.
- Contention: req0 and req1 both valid in the same IDLE cycle after reset. Required: req0 served first, req1 served next. A further simultaneous request then goes to req0 (alternation 0,1,0).
- Bubbles: req1 valid toggles 1,0,1,0 while streaming 8 bytes. Required: only 8 load strobes, in_cnt reaches 8 after 16 cycles, and req0_ready stays 0 throughout.
- Timeout: core_done held 0 after load with TIMEOUT=15. Required: err pulses once, 15 cycles after entering WAIT; no rsp_valid; FLUSH follows; busy drops.
- Transpose latch: req0_transpose=1 at grant, then 0 during LOAD. Required: core_transpose stays 1 until FLUSH, then 0.
- Reset mid-DRAIN: assert rst after 3 result bytes. Required: next cycle rsp_valid=0, state IDLE, core_rst=1 during rst, no rsp_last emitted.
